// File: rtl/deserial_pkg.sv
// Shared mode encodings and lane/beat helpers for the multi-lane deserialiser.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package deserial_pkg;

    typedef enum logic [1:0] {
        MODE_X1   = 2'd0,
        MODE_X2   = 2'd1,
        MODE_X4   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    // Active lane count for a mode; the reserved code behaves as single lane,
    // and a mode wider than the physical lanes falls back to all physical lanes.
    function automatic int lanes(input logic [1:0] mode, input int max_lanes);
        int k;
        case (mode)
            MODE_X2: k = 2;
            MODE_X4: k = 4;
            default: k = 1;
        endcase
        if (k > max_lanes) begin
            k = max_lanes;
        end
        return k;
    endfunction

    // Beats needed to assemble one word in the given mode.
    function automatic int beats(input logic [1:0] mode, input int wsize, input int max_lanes);
        return wsize / lanes(mode, max_lanes);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with count-based full/empty and registered read port.
// Latency: push visible in count/empty next cycle; pop returns rd_data/rd_vld one cycle later.
// Backpressure: none; a push while full is refused unless a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int WSIZE = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WSIZE-1:0]           push_data,
    input  logic                       pop,
    output logic [WSIZE-1:0]           rd_data,
    output logic                       rd_vld,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);

    logic [WSIZE-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [NW-1:0]    cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (cnt_q == NW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_ok  = pop & ~empty & ~clear;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the word.
    assign push_ok = push & ~clear & (~full | pop_ok);

    // Storage array; no reset needed since entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp_q] <= push_data;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else if (clear) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rp_q];
                rp_q    <= rp_q + AW'(1);
            end
            if (push_ok) begin
                wp_q <= wp_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + NW'(1);
                2'b01:   cnt_q <= cnt_q - NW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/deserial_mx.sv
// Multi-lane (x1/x2/x4) serial-to-parallel converter feeding a word FIFO.
// Latency: completing beat -> word counted next cycle; rd_en -> rd_vld/rd_data next cycle.
// Backpressure: source is never stalled; a word completing into a full FIFO is dropped and sets sticky overflow.
module deserial_mx
    import deserial_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int WSIZE     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic                       wr_vld,
    input  logic [LANES-1:0]           wr_data,
    output logic                       wr_last,
    output logic                       wr_full,
    output logic                       overflow,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic [WSIZE-1:0]           rd_data,
    output logic                       rd_empty,
    output logic [$clog2(DEPTH+1)-1:0] rd_count
);
    localparam int CW = $clog2(WSIZE);

    logic [1:0]       mode_q;
    logic [1:0]       mode_eff;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    last_idx;
    logic [2:0]       k;
    logic [3:0]       beat4;
    logic [WSIZE-1:0] beat_w;
    logic [WSIZE-1:0] sr_q;
    logic [WSIZE-1:0] sr_next;
    logic             push;
    logic             pop_acc;
    logic             drop;
    logic             overflow_q;

    // At a word boundary the live mode governs the first beat; mid-word the latched mode holds.
    assign mode_eff = (cnt_q == '0) ? mode : mode_q;
    assign k        = 3'(lanes(mode_eff, LANES));
    assign last_idx = CW'(beats(mode_eff, WSIZE, LANES) - 1);
    assign wr_last  = (cnt_q == last_idx);

    // Zero-extend the beat to four lanes and keep only the lanes active in this mode.
    always_comb begin
        beat4              = '0;
        beat4[LANES-1:0]   = wr_data;
        beat4              = beat4 & 4'((5'd1 << k) - 5'd1);
    end

    assign beat_w = WSIZE'(beat4);

    // Next shifter value: new beat enters at the LSB end (MSB-first) or the MSB end (LSB-first).
    always_comb begin
        if (MSB_FIRST) begin
            sr_next = (sr_q << k) | beat_w;
        end else begin
            sr_next = (sr_q >> k) | (beat_w << (WSIZE - int'(k)));
        end
    end

    assign push    = wr_vld & wr_last & ~clear;
    assign pop_acc = rd_en & ~rd_empty & ~clear;
    assign drop    = push & wr_full & ~pop_acc;

    // Mode latch, beat counter and shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_X1;
            cnt_q  <= '0;
            sr_q   <= '0;
        end else if (clear) begin
            cnt_q  <= '0;
            sr_q   <= '0;
        end else begin
            if (cnt_q == '0) begin
                mode_q <= mode;
            end
            if (wr_vld) begin
                sr_q  <= sr_next;
                cnt_q <= wr_last ? '0 : cnt_q + CW'(1);
            end
        end
    end

    // Sticky drop flag; only clear or reset releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

    sync_fifo #(
        .WSIZE (WSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (push),
        .push_data (sr_next),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .count     (rd_count),
        .full      (wr_full),
        .empty     (rd_empty)
    );

endmodule
